mux2_sel_arbiter: RTL and testbench
===================================

// Module: mux2_sel_arbiter
// PURPOSE
//  Round-robin arbiter for two request sources. Drives SEL of the downstream 2:1 gate-level mux.
//  The mux has multi-ns gate delays, so after any SEL change OUT_VALID is held low for SETTLE cycles.
//  OUT_VALID therefore marks cycles where the mux output is stable and belongs to the granted channel.
//  Sits directly upstream of the mux: it drives SEL and is the only writer of that net.
// PARAMETERS
//  BURST_MAX  4  max consecutive grant cycles for one channel while the other requests (>=1)
//  SETTLE     2  dead cycles after a SEL change before a grant is issued (>=1)
//  CNT_W      derived localparam = $clog2(max(BURST_MAX,SETTLE)+1); not overridable
// PORTS
//  CLK        in   1  single clock, all state on rising edge
//  RST_N      in   1  asynchronous, active-low reset
//  REQ_A      in   1  channel A requests mux path (level, held until served)
//  REQ_B      in   1  channel B requests mux path
//  SEL        out  1  to mux SEL: 0 = A, 1 = B
//  GNT_A      out  1  A owns stable mux output this cycle
//  GNT_B      out  1  B owns stable mux output this cycle
//  OUT_VALID  out  1  GNT_A | GNT_B; mux output settled
//  BUSY       out  1  state != IDLE
// BEHAVIOUR
//  - Reset (async, RST_N=0): SEL=0, GNT_A=GNT_B=0, OUT_VALID=0, BUSY=0, state=IDLE, counters=0.
//    The last-served channel resets to B, so A wins the first tie. This applies from any state, mid-burst included.
//  - All outputs are registered. GNT_A and GNT_B are never both 1.
//  - IDLE: no REQ -> stay. Otherwise pick winner W:
//    - only one requester -> that one;
//    - both requesting -> the channel != last-served.
//    - If W == SEL -> GRANT next edge (latency 1 cycle).
//    - Else SEL<=W, load settle count=SETTLE, -> SETTLE.
//  - SETTLE: GNTs low. Decrement each cycle. When count reaches 0:
//    - REQ_W still high -> GRANT;
//    - else -> IDLE, SEL held.
//    - REQ changes during SETTLE do not abort the settle.
//  - GRANT: GNT_W=1, OUT_VALID=1, burst count increments each cycle (saturates at BURST_MAX).
//    Exit rules, evaluated each cycle:
//    - REQ_W=0 and other REQ=1 -> switch: SEL<=other, last-served<=W, -> SETTLE.
//    - REQ_W=0 and other REQ=0 -> IDLE, SEL held, last-served<=W.
//    - burst==BURST_MAX and other REQ=1 -> switch as above. The grant drops on that same edge.
//    - burst==BURST_MAX and other REQ=0 -> remain in GRANT, counter saturated.
//    - Entering GRANT clears the burst count to 1.
//  - Latency from the REQ edge sample:
//    - 1 cycle when SEL already matches;
//    - 1+SETTLE cycles when SEL must toggle.
//  - SEL changes only on transitions into SETTLE, never while any GNT is high.
// STRUCTURE
//  - Package mux2_ctrl_pkg:
//    - typedef enum logic [1:0] {ST_IDLE=2'b00, ST_SETTLE=2'b01, ST_GRANT=2'b10} arb_state_t;
//    - localparams SEL_A=1'b0, SEL_B=1'b1.
//  - Sub-module mux2_settle_timer:
//    - load/decrement down-counter of CNT_W bits with a registered done flag;
//    - instantiated once.
//  - Top: winner logic, FSM, burst counter, output registers.
// TESTING (BURST_MAX=4, SETTLE=2; edge n = nth rising CLK after stimulus)
//  1. REQ_A=1 from reset -> GNT_A=1, OUT_VALID=1 after edge 1; SEL stays 0 throughout.
//  2. REQ_B=1 from reset:
//     - SEL=1 after edge 1, GNT_B=1 after edge 3;
//     - OUT_VALID=0 after edges 1-2.
//  3. REQ_A=REQ_B=1 held:
//     - GNT_A high 4 cycles, 2 dead cycles, GNT_B high 4 cycles, 2 dead, repeating;
//     - GNT_A&GNT_B never 1.
//  4. REQ_B=1 from reset, REQ_B drops after edge 1:
//     - IDLE after edge 3, GNT_B never asserts, SEL stays 1.
//  5. GNT_A active, REQ_A->0 with REQ_B=0:
//     - IDLE/BUSY=0 next edge, SEL=0;
//     - re-raise REQ_A -> GNT_A after 1 edge.
//  6. RST_N pulsed low mid-burst with GNT_B=1:
//     - SEL=0, GNT_B=0, OUT_VALID=0 immediately, without a clock edge;
//     - after release with both REQ high, A is granted first.

Source files
------------

// File: rtl/mux2_ctrl_pkg.sv
// Shared types and constants for the two-source mux SEL arbiter.
package mux2_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_GRANT  = 2'b10
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mux2_settle_timer.sv
// Load/decrement down-counter timing the dead cycles after a SEL change.
module mux2_settle_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTwo = CNT_W'(2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  // r_done is high during the final settle cycle: the next decrement reaches zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_done <= (i_load_val == CntOne);
    end else if (i_dec) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CntOne;
      end
      r_done <= (r_cnt == CntTwo);
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/mux2_sel_arbiter.sv
// Round-robin two-source arbiter driving the SEL of a slow 2:1 mux, with settle gaps.
module mux2_sel_arbiter
  import mux2_ctrl_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned SETTLE    = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_sel,
  output logic o_gnt_a,
  output logic o_gnt_b,
  output logic o_out_valid,
  output logic o_busy
);

  localparam int unsigned CNT_W = $clog2(max_u(BURST_MAX, SETTLE) + 1);
  localparam logic [CNT_W-1:0] BurstMaxC = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] SettleC   = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  arb_state_t       r_state;
  logic             r_sel;
  logic             r_last;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_burst;

  logic w_any_req;
  logic w_win;
  logic w_req_own;
  logic w_req_oth;
  logic w_switch;
  logic w_load;
  logic w_dec;
  logic w_tmr_done;

  // In SETTLE and GRANT the target/owner channel is always the current SEL.
  always_comb begin
    w_any_req = i_req_a | i_req_b;
    w_win     = SEL_A;
    if (i_req_a && i_req_b) begin
      w_win = ~r_last;
    end else if (i_req_b) begin
      w_win = SEL_B;
    end
    w_req_own = (r_sel == SEL_B) ? i_req_b : i_req_a;
    w_req_oth = (r_sel == SEL_B) ? i_req_a : i_req_b;
    w_switch  = (r_state == ST_GRANT) && w_req_oth && (!w_req_own || (r_burst == BurstMaxC));
    w_load    = ((r_state == ST_IDLE) && w_any_req && (w_win != r_sel)) || w_switch;
    w_dec     = (r_state == ST_SETTLE);
  end

  mux2_settle_timer #(
    .CNT_W(CNT_W)
  ) u_settle_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (SettleC),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= SEL_A;
      r_last  <= SEL_B;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_burst <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_busy <= 1'b1;
            if (w_win == r_sel) begin
              r_state <= ST_GRANT;
              r_gnt_a <= (w_win == SEL_A);
              r_gnt_b <= (w_win == SEL_B);
              r_valid <= 1'b1;
              r_burst <= CntOne;
            end else begin
              r_state <= ST_SETTLE;
              r_sel   <= w_win;
            end
          end
        end
        ST_SETTLE: begin
          if (w_tmr_done) begin
            if (w_req_own) begin
              r_state <= ST_GRANT;
              r_gnt_a <= (r_sel == SEL_A);
              r_gnt_b <= (r_sel == SEL_B);
              r_valid <= 1'b1;
              r_burst <= CntOne;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_GRANT: begin
          if (w_switch) begin
            r_state <= ST_SETTLE;
            r_sel   <= ~r_sel;
            r_last  <= r_sel;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_valid <= 1'b0;
          end else if (!w_req_own) begin
            r_state <= ST_IDLE;
            r_last  <= r_sel;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_burst != BurstMaxC) begin
            r_burst <= r_burst + CntOne;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt_a <= 1'b0;
          r_gnt_b <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sel       = r_sel;
  assign o_gnt_a     = r_gnt_a;
  assign o_gnt_b     = r_gnt_b;
  assign o_out_valid = r_valid;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Bench for mux2_sel_arbiter: per-cycle model comparison plus directed literal checks.
module tb_mux2_sel_arbiter;

  localparam int BURST = 4;
  localparam int SETL  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic sel, gnt_a, gnt_b, out_valid, busy;

  int checks = 0;
  int failures = 0;

  mux2_sel_arbiter #(
    .BURST_MAX(BURST),
    .SETTLE   (SETL)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_a    (req_a),
    .i_req_b    (req_b),
    .o_sel      (sel),
    .o_gnt_a    (gnt_a),
    .o_gnt_b    (gnt_b),
    .o_out_valid(out_valid),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: owner = channel holding the grant (-1 none), dead = settle cycles left.
  int m_sel = 0, m_last = 1, m_owner = -1, m_dead = 0, m_run = 0;

  task automatic model_reset();
    m_sel = 0; m_last = 1; m_owner = -1; m_dead = 0; m_run = 0;
  endtask

  task automatic model_step(input int ra, input int rb);
    int req[2];
    int w;
    req[0] = ra;
    req[1] = rb;
    if (m_owner >= 0) begin
      int o;
      o = 1 - m_owner;
      if (req[m_owner] == 0 || (m_run == BURST && req[o] == 1)) begin
        if (req[o] == 1 || req[m_owner] == 1) begin
          m_last = m_owner; m_owner = -1; m_sel = o; m_dead = SETL;
        end else begin
          m_last = m_owner; m_owner = -1;
        end
        if (req[m_last] == 0 && req[o] == 0) m_dead = 0;
      end else if (m_run < BURST) begin
        m_run++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0 && req[m_sel] == 1) begin
        m_owner = m_sel; m_run = 1;
      end
    end else if (ra == 1 || rb == 1) begin
      w = (ra == 1 && rb == 1) ? 1 - m_last : (rb == 1 ? 1 : 0);
      if (w == m_sel) begin
        m_owner = w; m_run = 1;
      end else begin
        m_sel = w; m_dead = SETL;
      end
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(int'(req_a), int'(req_b));
      #1;
      check("model_sel", sel, m_sel[0]);
      check("model_gnt_a", gnt_a, m_owner == 0);
      check("model_gnt_b", gnt_b, m_owner == 1);
      check("model_valid", out_valid, m_owner >= 0);
      check("model_busy", busy, (m_owner >= 0) || (m_dead > 0));
      check("gnt_exclusive", gnt_a & gnt_b, 1'b0);
    end
  end

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nedge(2);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    #1 rst_n = 1'b0;
    nedge(2);
    check("rst_sel", sel, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // A alone from reset: one-cycle latency, SEL untouched.
    req_a = 1'b1;
    nedge(1);
    check("t1_gnt_a", gnt_a, 1'b1);
    check("t1_valid", out_valid, 1'b1);
    nedge(3);
    check("t1_sel", sel, 1'b0);
    req_a = 1'b0;
    nedge(1);
    check("t5_busy", busy, 1'b0);
    check("t5_gnt_a", gnt_a, 1'b0);
    req_a = 1'b1;
    nedge(1);
    check("t5_regrant", gnt_a, 1'b1);
    req_a = 1'b0;
    nedge(1);

    // B alone from reset: SEL flips, two dead cycles, then grant.
    do_reset();
    req_b = 1'b1;
    nedge(1);
    check("t2_sel", sel, 1'b1);
    check("t2_valid_e1", out_valid, 1'b0);
    nedge(1);
    check("t2_valid_e2", out_valid, 1'b0);
    nedge(1);
    check("t2_gnt_b", gnt_b, 1'b1);
    nedge(1);

    // Async reset mid-burst.
    #2 rst_n = 1'b0;
    #1;
    check("t6_sel", sel, 1'b0);
    check("t6_gnt_b", gnt_b, 1'b0);
    check("t6_valid", out_valid, 1'b0);
    req_a = 1'b1;
    req_b = 1'b1;
    nedge(1);
    rst_n = 1'b1;

    // Both held: 4 A, 2 dead, 4 B, 2 dead, repeating.
    for (int k = 1; k <= 24; k++) begin
      int ph;
      nedge(1);
      ph = (k - 1) % 12;
      check("t3_gnt_a", gnt_a, ph < 4);
      check("t3_gnt_b", gnt_b, ph >= 6 && ph < 10);
    end
    req_a = 1'b0;
    req_b = 1'b0;

    // B raised then dropped during settle: settle completes, back to idle.
    do_reset();
    req_b = 1'b1;
    nedge(1);
    check("t4_sel_e1", sel, 1'b1);
    req_b = 1'b0;
    nedge(1);
    check("t4_busy_e2", busy, 1'b1);
    check("t4_gnt_b_e2", gnt_b, 1'b0);
    nedge(1);
    check("t4_busy_e3", busy, 1'b0);
    check("t4_sel_e3", sel, 1'b1);
    check("t4_gnt_b_e3", gnt_b, 1'b0);
    nedge(2);

    // Irregular request pattern, covered by the model only.
    for (int k = 0; k < 40; k++) begin
      req_a = ((k % 7) < 4);
      req_b = ((k % 5) > 1);
      nedge(1);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    nedge(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
